vol_ramp_gain: RTL and testbench
================================

Name: vol_ramp_gain

Overview:
- Parametrised successor to the pedal board's key-driven volume register.
- Debounce-free edge detection on the raw DE2 volume keys sets a target level.
- A zipper-free gain ramp moves the applied gain towards that target.
- The gain is applied to a CHANNELS-wide sample frame with saturation; sits between Pedal_Board output and the audio interface DAC data.

Parameters:
- DATA_W, 16, signed sample width per channel.
- CHANNELS, 2, channels per frame, packed channel 0 in LSBs.
- LEVEL_W, 4, level register width; levels 0..2^LEVEL_W-1.
- DEFAULT_LEVEL, 8, level after reset (unity gain when 8 with defaults).
- RAMP_DIV, 256, clocks per fine gain step (>=2).

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- Vol_up, input, 1, raw active-low key (0 = pressed), asynchronous to Clk.
- Vol_down, input, 1, raw active-low key (0 = pressed), asynchronous to Clk.
- Sample_valid, input, 1, one-cycle strobe qualifying Sample_in.
- Sample_in, input, CHANNELS*DATA_W, packed signed samples.
- Sample_out, output, CHANNELS*DATA_W, packed gained, saturated samples.
- Sample_out_valid, output, 1, strobe qualifying Sample_out.
- Level, output, LEVEL_W, current target level.
- Busy, output, 1, high while applied gain differs from target.

Behaviour:
- Keys:
  - Two-flop synchroniser on each key; sync flops reset to 1 (released), so no edge is generated out of reset.
  - A press is a 1->0 transition of the synchronised signal: one event per press, however long the key is held.
- Level:
  - Up event: Level+1, saturating at 2^LEVEL_W-1.
  - Down event: Level-1, saturating at 0.
  - Up and down events in the same cycle: no change.
- Gain:
  - GW = LEVEL_W+4, unsigned register G; target T = Level<<4. Unity gain is G = 2^(GW-1) (128 with defaults).
  - Ramp counter C counts 0..RAMP_DIV-1 while G!=T.
  - At C==RAMP_DIV-1: G steps by +/-1 towards T and C wraps to 0.
  - When G==T, C is held at 0.
  - A change of T mid-ramp redirects the ramp immediately; C is not cleared.
- Busy = (G != T), combinational from registers.
- Datapath, 2-stage pipeline, latency 2:
  - Stage 1, on Sample_valid: P[ch] = signed(Sample_in[ch]) * {0,G}, width DATA_W+GW+1. G is sampled once per frame, so all channels use the same G.
  - Stage 2: Y = P >>> (GW-1), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Sample_out_valid is high exactly 2 cycles after Sample_valid.
  - Back-to-back Sample_valid is accepted every cycle.
  - Sample_out holds its last value when not valid.
- Reset (any cycle, including mid-ramp or mid-pipeline):
  - Level=DEFAULT_LEVEL, G=T=DEFAULT_LEVEL<<4, C=0.
  - Sample_out=0, Sample_out_valid=0, pipeline valids cleared, Busy=0.
  - In-flight samples are discarded.

Test Plan (bench uses RAMP_DIV=4, other parameters at defaults):
- Reset, then Sample_in={0x1000,0xF000} with a valid pulse -> Sample_out={0x1000,0xF000} with Sample_out_valid exactly 2 cycles later; Level=8, Busy=0.
- One Vol_up press held 50 cycles -> Level=9 once; Busy high for 16*4=64 cycles. Then input 0x1000 -> 0x1200 (0x1000*144>>7).
- Press Vol_up 10 times -> Level saturates at 15, G ramps to 240. Input 0x7000 -> 0x7FFF; input 0x9000 -> 0x8000 (both saturated).
- Press Vol_down 20 times -> Level=0 with no wrap, G ramps to 0, any input -> 0. Simultaneous up and down press -> Level unchanged.
- Vol_up press, then Vol_down press 10 cycles later mid-ramp -> G reverses towards 128 without overshooting past 128 on return; Busy drops when G==128.
- Assert Reset with a sample in stage 1 and G mid-ramp -> no Sample_out_valid follows; Level=8, G=128, Busy=0 on the next cycle.

Source files
------------

// File: rtl/vol_ramp_gain_if.sv
// Sample-frame bus between the effects chain and the gain stage.
// The master drives frames in and receives the gained frames back.
interface vol_ramp_gain_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
);
    logic                         sample_valid;
    logic [CHANNELS*DATA_W-1:0]   sample_in;
    logic [CHANNELS*DATA_W-1:0]   sample_out;
    logic                         sample_out_valid;

    modport master (
        output sample_valid,
        output sample_in,
        input  sample_out,
        input  sample_out_valid
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        output sample_out,
        output sample_out_valid
    );
endinterface

// File: rtl/vol_ramp_gain.sv
// Key-driven volume level with a zipper-free gain ramp and a saturating
// two-stage gain datapath over a packed multi-channel sample frame.
module vol_ramp_gain #(
    parameter int DATA_W        = 16,
    parameter int CHANNELS      = 2,
    parameter int LEVEL_W       = 4,
    parameter int DEFAULT_LEVEL = 8,
    parameter int RAMP_DIV      = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vol_up_i,
    input  logic               vol_down_i,
    vol_ramp_gain_if.slave     smp,
    output logic [LEVEL_W-1:0] level_o,
    output logic               busy_o
);
    localparam int GW = LEVEL_W + 4;
    localparam int PW = DATA_W + GW + 1;
    localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

    localparam logic [LEVEL_W-1:0] LVL_RST = LEVEL_W'(DEFAULT_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
    localparam logic [GW-1:0]      GAIN_RST = {LVL_RST, 4'b0000};
    localparam logic [CW-1:0]      CNT_TC = CW'(RAMP_DIV - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // [0],[1] synchroniser flops, [2] previous synchronised value for edge detect
    logic [2:0]         up_sync_q, dn_sync_q;
    logic               up_evt, dn_evt;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [GW-1:0]      gain_q, gain_d, target;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic signed [PW-1:0]       prod_q [CHANNELS];
    logic signed [PW-1:0]       prod_d [CHANNELS];
    logic signed [PW-1:0]       shifted [CHANNELS];
    logic                       v1_q, v2_q;
    logic [CHANNELS*DATA_W-1:0] out_q, out_d;

    assign up_evt = up_sync_q[2] & ~up_sync_q[1];
    assign dn_evt = dn_sync_q[2] & ~dn_sync_q[1];
    assign target = {level_q, 4'b0000};

    always_comb begin
        level_d = level_q;
        if (up_evt && !dn_evt && level_q != LVL_MAX) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (dn_evt && !up_evt && level_q != '0) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    // The counter keeps running across a target change so a redirect costs no extra time.
    always_comb begin
        gain_d = gain_q;
        cnt_d  = '0;
        if (gain_q != target) begin
            if (cnt_q == CNT_TC) begin
                cnt_d  = '0;
                gain_d = (gain_q < target) ? gain_q + GW'(1) : gain_q - GW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        out_d = out_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            prod_d[ch]  = PW'($signed(smp.sample_in[ch*DATA_W +: DATA_W]))
                        * $signed({{(PW-GW){1'b0}}, gain_q});
            shifted[ch] = prod_q[ch] >>> (GW - 1);
            if (shifted[ch] > SAT_MAX) begin
                out_d[ch*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            end else if (shifted[ch] < SAT_MIN) begin
                out_d[ch*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            end else begin
                out_d[ch*DATA_W +: DATA_W] = shifted[ch][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_sync_q <= '1;
            dn_sync_q <= '1;
            level_q   <= LVL_RST;
            gain_q    <= GAIN_RST;
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_q     <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                prod_q[ch] <= '0;
            end
        end else begin
            up_sync_q <= {up_sync_q[1:0], vol_up_i};
            dn_sync_q <= {dn_sync_q[1:0], vol_down_i};
            level_q   <= level_d;
            gain_q    <= gain_d;
            cnt_q     <= cnt_d;
            v1_q      <= smp.sample_valid;
            v2_q      <= v1_q;
            if (smp.sample_valid) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    prod_q[ch] <= prod_d[ch];
                end
            end
            if (v1_q) begin
                out_q <= out_d;
            end
        end
    end

    assign smp.sample_out       = out_q;
    assign smp.sample_out_valid = v2_q;
    assign level_o              = level_q;
    assign busy_o               = (gain_q != target);
endmodule

// File: tb/tb_vol_ramp_gain.sv
// Directed bench for vol_ramp_gain with a fast ramp (RAMP_DIV=4).
module tb_vol_ramp_gain;
    localparam int DATA_W   = 16;
    localparam int CHANNELS = 2;
    localparam int LEVEL_W  = 4;
    localparam int RAMP_DIV = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vol_up = 1'b1;
    logic               vol_down = 1'b1;
    logic [LEVEL_W-1:0] level;
    logic               busy;

    vol_ramp_gain_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) s_if ();

    vol_ramp_gain #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .LEVEL_W(LEVEL_W),
        .DEFAULT_LEVEL(8), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk_i(clk), .rst_i(rst), .vol_up_i(vol_up), .vol_down_i(vol_down),
        .smp(s_if.slave), .level_o(level), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          lvl;
        logic [15:0] i0, i1, e0, e1;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn);
        @(posedge clk); #1;
        if (up) vol_up = 1'b0;
        if (dn) vol_down = 1'b0;
        repeat (3) @(posedge clk);
        #1 vol_up = 1'b1; vol_down = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic set_level(input int tgt);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (int'(level) < tgt) press(1'b1, 1'b0);
            else if (int'(level) > tgt) press(1'b0, 1'b1);
            else break;
        end
        check("set_level", 32'(level), 32'(tgt));
        wait_idle("set_level");
    endtask

    task automatic send_frame(input logic [15:0] a0, a1, e0, e1, input string nm);
        @(posedge clk); #1;
        s_if.sample_valid = 1'b1;
        s_if.sample_in    = {a1, a0};
        @(posedge clk); #1;
        s_if.sample_valid = 1'b0;
        @(negedge clk);
        check({nm, " valid@1"}, {31'd0, s_if.sample_out_valid}, 32'd0);
        @(negedge clk);
        check({nm, " valid@2"}, {31'd0, s_if.sample_out_valid}, 32'd1);
        check({nm, " data"}, s_if.sample_out, {e1, e0});
        @(negedge clk);
        check({nm, " valid@3"}, {31'd0, s_if.sample_out_valid}, 32'd0);
        check({nm, " hold"}, s_if.sample_out, {e1, e0});
    endtask

    initial begin
        int changes, busy_cnt, ov_cnt;
        logic [LEVEL_W-1:0] prev;

        vecs[0] = '{8,  16'h1000, 16'hF000, 16'h1000, 16'hF000};
        vecs[1] = '{8,  16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        vecs[2] = '{9,  16'h1000, 16'hF000, 16'h1200, 16'hEE00};
        vecs[3] = '{15, 16'h7000, 16'h9000, 16'h7FFF, 16'h8000};
        vecs[4] = '{15, 16'h0100, 16'hFF00, 16'h01E0, 16'hFE20};
        vecs[5] = '{0,  16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        vecs[6] = '{4,  16'h1000, 16'h8000, 16'h0800, 16'hC000};
        vecs[7] = '{12, 16'h0003, 16'hFFFD, 16'h0004, 16'hFFFB};

        s_if.sample_valid = 1'b0;
        s_if.sample_in    = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset level", 32'(level), 32'd8);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset out_valid", {31'd0, s_if.sample_out_valid}, 32'd0);
        check("reset sample_out", s_if.sample_out, 32'd0);
        send_frame(16'h1000, 16'hF000, 16'h1000, 16'hF000, "unity");

        // One long press: a single level step and a 16-step ramp.
        changes = 0; busy_cnt = 0; prev = level;
        @(posedge clk); #1 vol_up = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (i == 50) vol_up = 1'b1;
            @(negedge clk);
            if (level != prev) changes++;
            prev = level;
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check("held press changes", 32'(changes), 32'd1);
        check("held press level", 32'(level), 32'd9);
        check("held press busy cycles", 32'(busy_cnt), 32'd64);

        for (int i = 0; i < 10; i++) press(1'b1, 1'b0);
        check("up saturate", 32'(level), 32'd15);
        press(1'b1, 1'b1);
        check("simul at 15", 32'(level), 32'd15);
        wait_idle("to 15");
        send_frame(16'h7000, 16'h9000, 16'h7FFF, 16'h8000, "sat 15");

        for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
        check("down saturate", 32'(level), 32'd0);
        press(1'b1, 1'b1);
        check("simul at 0", 32'(level), 32'd0);
        wait_idle("to 0");
        send_frame(16'h1234, 16'hEDCB, 16'h0000, 16'h0000, "zero gain");

        // Up then down ten cycles later: ramp reverses without a counter restart.
        do_reset();
        busy_cnt = 0;
        @(posedge clk); #1 vol_up = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3)  vol_up = 1'b1;
            if (i == 10) vol_down = 1'b0;
            if (i == 13) vol_down = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check("reverse busy cycles", 32'(busy_cnt), 32'd16);
        check("reverse level", 32'(level), 32'd8);
        send_frame(16'h1000, 16'hF000, 16'h1000, 16'hF000, "reverse gain");

        // Reset with a frame in stage 1 and the ramp in progress.
        press(1'b1, 1'b0);
        @(negedge clk);
        check("mid-ramp busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        s_if.sample_valid = 1'b1;
        s_if.sample_in    = {16'h2000, 16'h2000};
        @(posedge clk); #1;
        s_if.sample_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("flush level", 32'(level), 32'd8);
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush sample_out", s_if.sample_out, 32'd0);
        ov_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_if.sample_out_valid) ov_cnt++;
            @(negedge clk);
        end
        check("flush no valid", 32'(ov_cnt), 32'd0);

        do_reset();
        for (int v = 0; v < 8; v++) begin
            set_level(vecs[v].lvl);
            send_frame(vecs[v].i0, vecs[v].i1, vecs[v].e0, vecs[v].e1,
                       $sformatf("vec%0d", v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
